// File: rtl/exp2_decode.sv
// exp2_decode: converts an 8-bit log code {exp[4:0], man[2:0]} back to an
// approximate 32-bit linear magnitude by shifting {1, man, lsb} left exp times.
// Optional feature macro: EXP2_MIDPOINT_EN (lsb = 1, bucket midpoint);
// when undefined lsb = 0 and the bucket floor is reconstructed.
module exp2_decode (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  log_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    input  logic        ready_out
);

`ifdef EXP2_MIDPOINT_EN
    localparam logic LSB = 1'b1;
`else
    localparam logic LSB = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_n;
    logic [35:0] acc, acc_n;
    logic [4:0]  cnt, cnt_n;
    logic        rdy, rdy_n;
    logic        vld, vld_n;

    // State and datapath registers; reset discards any in-flight code.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            rdy   <= 1'b0;
            vld   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            rdy   <= rdy_n;
            vld   <= vld_n;
        end
    end

    // Next-state logic: load, shift exp times, then present until handshake.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        rdy_n   = rdy;
        vld_n   = vld;
        case (state)
            IDLE: begin
                // ready rises on the first edge after reset release
                rdy_n = 1'b1;
                if (valid_in && rdy) begin
                    acc_n   = {31'b0, 1'b1, log_in[2:0], LSB};
                    cnt_n   = log_in[7:3];
                    rdy_n   = 1'b0;
                    state_n = (log_in[7:3] == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_n = {acc[34:0], 1'b0};
                cnt_n = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!vld) begin
                    vld_n = 1'b1;
                end else if (ready_out) begin
                    vld_n   = 1'b0;
                    rdy_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ready_in  = rdy;
    assign valid_out = vld;
    assign data_out  = acc[35:4];

endmodule

// File: tb/tb_exp2_decode.sv
// Self-checking bench for exp2_decode: transaction-level timing/value model
// compared every cycle, directed literal cases, async reset, random traffic.
module tb_exp2_decode;

`ifdef EXP2_MIDPOINT_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic        clk_in;
    logic        rst_n_in;
    logic [7:0]  log_in;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    exp2_decode dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .log_in    (log_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference value: ({1,man,lsb} << exp) >> 4 in plain arithmetic.
    function automatic logic [31:0] ref_val(input logic [7:0] code);
        longint v;
        v = (longint'(16 + 2 * int'(code[2:0]) + int'(LSB)) << code[7:3]) >> 4;
        return v[31:0];
    endfunction

    // Behavioural model: handshake timing expressed in edge numbers.
    logic        m_ready, m_valid, m_busy;
    logic [31:0] m_data;
    int          m_rise;
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_data  = '0;
            m_rise  = 0;
        end else begin
            bit take, hs;
            edge_n++;
            take = m_ready && valid_in;
            hs   = m_valid && ready_out;
            if (hs) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
                m_busy  = 1'b0;
            end else if (m_busy && !m_valid && edge_n == m_rise) begin
                m_valid = 1'b1;
            end else if (!m_busy && !m_ready) begin
                m_ready = 1'b1;
            end
            if (take) begin
                m_busy  = 1'b1;
                m_ready = 1'b0;
                m_rise  = edge_n + int'(log_in[7:3]) + 1;
                m_data  = ref_val(log_in);
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk_in) begin
        chk("ready_in", {31'b0, ready_in}, {31'b0, m_ready});
        chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        if (m_valid || !rst_n_in)
            chk("data_out", data_out, m_data);
    end

    task automatic xfer(input logic [7:0] code, input int hold, input logic [31:0] want);
        int t, a;
        logic [7:0] c;
        c = code;
        t = 0;
        while (!ready_in && t < 64) begin
            @(negedge clk_in);
            t++;
        end
        chk("ready_wait", {31'b0, ready_in}, 32'd1);
        if (!ready_in) return;
        log_in    = code;
        valid_in  = 1'b1;
        ready_out = (hold == 0);
        @(negedge clk_in);
        valid_in = 1'b0;
        a = edge_n;
        t = 0;
        while (!valid_out && t < 64) begin
            @(negedge clk_in);
            t++;
        end
        chk("valid_wait", {31'b0, valid_out}, 32'd1);
        chk("latency", 32'(edge_n - a), 32'(int'(c[7:3]) + 1));
        chk("value", data_out, want);
        for (int i = 0; i < hold; i++) begin
            valid_in = 1'b1;
            log_in   = 8'h08;
            @(negedge clk_in);
            chk("held_value", data_out, want);
            chk("held_ready", {31'b0, ready_in}, 32'd0);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(negedge clk_in);
        chk("ready_after_hs", {31'b0, ready_in}, 32'd1);
        chk("valid_after_hs", {31'b0, valid_out}, 32'd0);
    endtask

    initial begin
        int t;
        rst_n_in  = 1'b0;
        valid_in  = 1'b0;
        log_in    = '0;
        ready_out = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("reset_data", data_out, 32'd0);
        chk("reset_ready", {31'b0, ready_in}, 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("ready_one_edge", {31'b0, ready_in}, 32'd1);

        xfer(8'h00, 0, 32'h0000_0001);
        xfer(8'h2D, 0, LSB ? 32'd54 : 32'd52);
        xfer(8'hFF, 0, LSB ? 32'hF800_0000 : 32'hF000_0000);
        xfer(8'h18, 10, 32'd8);
        xfer(8'h08, 0, 32'd2);
        xfer(8'h10, 0, 32'd4);

        // asynchronous reset in the middle of a long shift
        t = 0;
        while (!ready_in && t < 64) begin
            @(negedge clk_in);
            t++;
        end
        log_in   = 8'hFF;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (5) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async_valid", {31'b0, valid_out}, 32'd0);
        chk("async_data", data_out, 32'd0);
        chk("async_ready", {31'b0, ready_in}, 32'd0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("ready_after_rerelease", {31'b0, ready_in}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            chk("no_stale_valid", {31'b0, valid_out}, 32'd0);
        end

        // random traffic, model checks every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_in);
            valid_in  = ($urandom_range(0, 2) != 0);
            log_in    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                    : {5'($urandom_range(0, 6)), 3'($urandom_range(0, 7))};
            ready_out = ($urandom_range(0, 3) != 0);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (40) @(negedge clk_in);
        chk("drained", {31'b0, valid_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
